// File: rtl/msg_req_arbiter_pkg.sv
// Shared types and constants for the messenger request arbiter.
package msg_req_arbiter_pkg;

    localparam int NREQ = 5;
    localparam int IDXW = 3;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_OFFER,
        ARB_SERVICE
    } arb_state_t;

    localparam logic [IDXW-1:0] REQ_NET   = 3'd0;
    localparam logic [IDXW-1:0] REQ_ERROR = 3'd1;
    localparam logic [IDXW-1:0] REQ_INT   = 3'd2;
    localparam logic [IDXW-1:0] REQ_EU    = 3'd3;
    localparam logic [IDXW-1:0] REQ_BKPT  = 3'd4;

    localparam logic [NREQ-1:0] HPMASK_DEF     = 5'b10010;
    localparam logic [NREQ-1:0] EDGEMASK_DEF   = 5'b00100;
    localparam logic [3:0]      STARVE_LIM_DEF = 4'd8;

    function automatic logic [IDXW-1:0] next_idx(input logic [IDXW-1:0] i);
        return (i == IDXW'(NREQ - 1)) ? '0 : i + 1'b1;
    endfunction

endpackage

// File: rtl/msg_req_arbiter_if.sv
// Request/grant bundle between the request lines, the arbiter and the microcontroller.
interface msg_req_arbiter_if;
    import msg_req_arbiter_pkg::*;

    logic [NREQ-1:0] req;
    logic            gntv;
    logic [IDXW-1:0] gntidx;
    logic            gntack;
    logic            done;
    logic            busy;
    logic [NREQ-1:0] pend;
    logic            starved;

    modport master (
        output req, gntack, done,
        input  gntv, gntidx, busy, pend, starved
    );

    modport slave (
        input  req, gntack, done,
        output gntv, gntidx, busy, pend, starved
    );

endinterface

// File: rtl/msg_req_arbiter_rr_pick.sv
// Combinational round-robin picker: first set bit at or after the pointer, wrapping.
module msg_req_arbiter_rr_pick
    import msg_req_arbiter_pkg::*;
(
    input  logic [NREQ-1:0] i_req,
    input  logic [IDXW-1:0] i_ptr,
    output logic            o_found,
    output logic [IDXW-1:0] o_idx
);

    logic [IDXW-1:0] w_j;

    always_comb begin
        o_found = 1'b0;
        o_idx   = '0;
        w_j     = '0;
        for (int k = 0; k < NREQ; k++) begin
            w_j = IDXW'((int'(i_ptr) + k) % NREQ);
            if (!o_found && i_req[w_j]) begin
                o_found = 1'b1;
                o_idx   = w_j;
            end
        end
    end

endmodule

// File: rtl/msg_req_arbiter.sv
// Captures request lines, selects one source and holds it in service until firmware signals done.
// state       | meaning
// ARB_IDLE    | nothing offered; a pending source is picked and registered
// ARB_OFFER   | winner offered on gntv/gntidx, waiting for gntack
// ARB_SERVICE | source in service, waiting for done
module msg_req_arbiter
    import msg_req_arbiter_pkg::*;
#(
    parameter logic [NREQ-1:0] HPMASK     = HPMASK_DEF,
    parameter logic [NREQ-1:0] EDGEMASK   = EDGEMASK_DEF,
    parameter logic [3:0]      STARVE_LIM = STARVE_LIM_DEF
) (
    input logic               i_clk,
    input logic               i_resetn,
    msg_req_arbiter_if.slave  io_bus
);

    arb_state_t      r_state, w_state_nxt;
    logic [NREQ-1:0] r_pend, r_req_d;
    logic [IDXW-1:0] r_gntidx, r_rr_ptr;
    logic [3:0]      r_starve_cnt;
    logic            r_starved;

    logic [NREQ-1:0] w_lp_pend, w_hp_pend, w_set, w_clr;
    logic [IDXW-1:0] w_rr_idx, w_hp_idx, w_win_idx;
    logic            w_rr_found, w_hp_found, w_force_lp;
    logic            w_load_gnt, w_ack_take, w_done_take, w_gnt_is_hp;

    assign w_lp_pend = r_pend & ~HPMASK;
    assign w_hp_pend = r_pend & HPMASK;

    msg_req_arbiter_rr_pick u_lp_pick (
        .i_req   (w_lp_pend),
        .i_ptr   (r_rr_ptr),
        .o_found (w_rr_found),
        .o_idx   (w_rr_idx)
    );

    // Lowest index wins inside the urgent class, so scan downward and keep the last hit.
    always_comb begin
        w_hp_found = 1'b0;
        w_hp_idx   = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (w_hp_pend[k]) begin
                w_hp_found = 1'b1;
                w_hp_idx   = IDXW'(k);
            end
        end
    end

    assign w_force_lp = (r_starve_cnt == STARVE_LIM) && w_rr_found;
    assign w_win_idx  = (w_force_lp || !w_hp_found) ? w_rr_idx : w_hp_idx;

    always_ff @(posedge i_clk) begin
        if (!i_resetn) r_state <= ARB_IDLE;
        else           r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ARB_IDLE:    if (w_hp_found || w_rr_found) w_state_nxt = ARB_OFFER;
            ARB_OFFER:   if (io_bus.gntack)            w_state_nxt = ARB_SERVICE;
            ARB_SERVICE: if (io_bus.done)              w_state_nxt = ARB_IDLE;
            default:                                   w_state_nxt = ARB_IDLE;
        endcase
    end

    always_comb begin
        w_load_gnt  = (r_state == ARB_IDLE) && (w_hp_found || w_rr_found);
        w_ack_take  = (r_state == ARB_OFFER) && io_bus.gntack;
        w_done_take = (r_state == ARB_SERVICE) && io_bus.done;
        w_gnt_is_hp = HPMASK[r_gntidx];
        w_clr       = w_done_take ? (NREQ'(1) << r_gntidx) : '0;
        w_set       = (io_bus.req & ~EDGEMASK) | (io_bus.req & ~r_req_d & EDGEMASK);
    end

    assign io_bus.gntv    = (r_state == ARB_OFFER);
    assign io_bus.busy    = (r_state == ARB_SERVICE);
    assign io_bus.gntidx  = r_gntidx;
    assign io_bus.pend    = r_pend;
    assign io_bus.starved = r_starved;

    always_ff @(posedge i_clk) begin
        if (!i_resetn) begin
            r_pend       <= '0;
            r_req_d      <= '0;
            r_gntidx     <= '0;
            r_rr_ptr     <= '0;
            r_starve_cnt <= '0;
            r_starved    <= 1'b0;
        end else begin
            r_req_d   <= io_bus.req;
            r_pend    <= (r_pend & ~w_clr) | w_set;
            r_starved <= w_load_gnt && w_force_lp;
            if (w_load_gnt)
                r_gntidx <= w_win_idx;
            if (w_ack_take && !w_gnt_is_hp)
                r_rr_ptr <= next_idx(r_gntidx);
            // The counter only measures starvation while somebody in the LP class is waiting.
            if (!(|w_lp_pend))
                r_starve_cnt <= '0;
            else if (w_ack_take)
                r_starve_cnt <= !w_gnt_is_hp ? 4'd0 :
                                (r_starve_cnt == STARVE_LIM) ? r_starve_cnt : r_starve_cnt + 4'd1;
        end
    end

endmodule

// File: tb/tb_msg_req_arbiter.sv
// Directed scenarios plus randomized traffic checked every cycle against a behavioural model.
module tb_msg_req_arbiter;

    localparam bit [4:0] HP   = 5'b10010;
    localparam bit [4:0] EDGE = 5'b00100;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;
    bit   chk_en  = 1'b0;

    msg_req_arbiter_if bus ();

    msg_req_arbiter dut (
        .i_clk    (clk),
        .i_resetn (rstn),
        .io_bus   (bus)
    );

    always #5 clk = ~clk;

    // Model: phase 0 = nothing offered, 1 = offered, 2 = in service.
    bit [4:0] m_pend, m_req_d;
    int       m_phase, m_idx, m_rr, m_sc;
    bit       m_starved;

    function automatic int rr_search(input bit [4:0] v, input int from);
        for (int k = 0; k < 5; k++) begin
            int j;
            j = (from + k) % 5;
            if (v[j] && !HP[j]) return j;
        end
        return -1;
    endfunction

    always @(posedge clk) begin : model
        bit [4:0] set_v, clr_v, lp;
        int       w, nsc;
        if (!rstn) begin
            m_pend = '0; m_req_d = '0; m_phase = 0; m_idx = 0;
            m_rr = 0; m_sc = 0; m_starved = 1'b0;
        end else begin
            lp    = m_pend & ~HP;
            set_v = (bus.req & ~EDGE) | (bus.req & ~m_req_d & EDGE);
            clr_v = '0;
            nsc   = m_sc;
            if (lp == 0) nsc = 0;
            else if (m_phase == 1 && bus.gntack) nsc = HP[m_idx] ? ((m_sc < 8) ? m_sc + 1 : 8) : 0;
            m_starved = 1'b0;
            case (m_phase)
                0: if (m_pend != 0) begin
                    w = -1;
                    if (m_sc == 8 && lp != 0) begin
                        w = rr_search(m_pend, m_rr);
                        m_starved = 1'b1;
                    end else if ((m_pend & HP) != 0) begin
                        for (int k = 0; k < 5; k++) if (w < 0 && m_pend[k] && HP[k]) w = k;
                    end else begin
                        w = rr_search(m_pend, m_rr);
                    end
                    m_idx   = w;
                    m_phase = 1;
                end
                1: if (bus.gntack) begin
                    if (!HP[m_idx]) m_rr = (m_idx + 1) % 5;
                    m_phase = 2;
                end
                default: if (bus.done) begin
                    clr_v[m_idx] = 1'b1;
                    m_phase = 0;
                end
            endcase
            m_sc    = nsc;
            m_pend  = (m_pend & ~clr_v) | set_v;
            m_req_d = bus.req;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("model_gntv",    int'(bus.gntv),    int'(m_phase == 1));
            chk("model_busy",    int'(bus.busy),    int'(m_phase == 2));
            chk("model_gntidx",  int'(bus.gntidx),  m_idx);
            chk("model_pend",    int'(bus.pend),    int'(m_pend));
            chk("model_starved", int'(bus.starved), int'(m_starved));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_gntv(input int max_cyc);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < max_cyc && !seen; i++) begin
            if (bus.gntv) seen = 1'b1;
            else step();
        end
        if (!seen) chk("gntv_timeout", 0, 1);
    endtask

    task automatic do_grant(input int exp_idx);
        wait_gntv(40);
        chk("grant_idx", int'(bus.gntidx), exp_idx);
        bus.gntack = 1'b1; step(); bus.gntack = 1'b0;
        bus.done   = 1'b1; step(); bus.done   = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.req = '0; bus.gntack = 1'b0; bus.done = 1'b0;
        rstn = 1'b0;
        step();
        chk_en = 1'b1;
        step();
        chk("rst_gntv",    int'(bus.gntv),    0);
        chk("rst_gntidx",  int'(bus.gntidx),  0);
        chk("rst_busy",    int'(bus.busy),    0);
        chk("rst_pend",    int'(bus.pend),    0);
        chk("rst_starved", int'(bus.starved), 0);
        rstn = 1'b1;
        step();

        // EU and NET together: NET first from pointer 0, then EU
        bus.req = 5'b01001; step(); bus.req = '0;
        chk("t1_pend", int'(bus.pend), 5'b01001);
        step();
        chk("t1_gntv", int'(bus.gntv), 1);
        chk("t1_idx0", int'(bus.gntidx), 0);
        bus.gntack = 1'b1; step(); bus.gntack = 1'b0;
        chk("t1_busy", int'(bus.busy), 1);
        bus.done = 1'b1; step(); bus.done = 1'b0;
        chk("t1_pend_after", int'(bus.pend), 5'b01000);
        step();
        chk("t1_idx3", int'(bus.gntidx), 3);
        do_grant(3);

        // ERROR raised while NET is in service: no preemption
        bus.req = 5'b00001; step(); bus.req = '0;
        wait_gntv(10);
        chk("t2_idx0", int'(bus.gntidx), 0);
        bus.gntack = 1'b1; step(); bus.gntack = 1'b0;
        bus.req = 5'b00010; step(); bus.req = '0; step();
        chk("t2_busy", int'(bus.busy), 1);
        chk("t2_hold", int'(bus.gntidx), 0);
        bus.done = 1'b1; step(); bus.done = 1'b0;
        chk("t2_gap", int'(bus.gntv), 0);
        step();
        chk("t2_gntv", int'(bus.gntv), 1);
        chk("t2_idx1", int'(bus.gntidx), 1);
        do_grant(1);

        // INT pulse during service is latched; INT held after done does not re-pend
        bus.req = 5'b00001; step(); bus.req = '0;
        wait_gntv(10);
        bus.gntack = 1'b1; step(); bus.gntack = 1'b0;
        bus.req = 5'b00100; step(); bus.req = '0; step();
        chk("t3_latched", int'(bus.pend), 5'b00101);
        bus.done = 1'b1; step(); bus.done = 1'b0;
        do_grant(2);
        bus.req = 5'b00100; step();
        do_grant(2);
        step(); step();
        chk("t3_no_repend", int'(bus.pend), 0);
        bus.req = '0; step();

        // BKPT held with EU pending: 8 BKPT grants then forced EU
        bus.req = 5'b11000; step(); bus.req = 5'b10000;
        for (int i = 0; i < 8; i++) begin
            wait_gntv(10);
            chk("t4_bkpt", int'(bus.gntidx), 4);
            chk("t4_nostarve", int'(bus.starved), 0);
            bus.gntack = 1'b1; step(); bus.gntack = 1'b0;
            bus.done   = 1'b1; step(); bus.done   = 1'b0;
        end
        wait_gntv(10);
        chk("t4_eu", int'(bus.gntidx), 3);
        chk("t4_starved", int'(bus.starved), 1);
        bus.gntack = 1'b1; step(); bus.gntack = 1'b0;
        chk("t4_pulse_end", int'(bus.starved), 0);
        bus.done = 1'b1; step(); bus.done = 1'b0;
        bus.req = '0;
        do_grant(4);
        step();
        chk("t4_clean", int'(bus.pend), 0);

        // Reset during offer abandons the grant
        bus.req = 5'b01000; step(); bus.req = '0;
        wait_gntv(10);
        chk("t5_idx3", int'(bus.gntidx), 3);
        rstn = 1'b0; step(); rstn = 1'b1;
        chk("t5_gntv", int'(bus.gntv), 0);
        chk("t5_pend", int'(bus.pend), 0);
        chk("t5_busy", int'(bus.busy), 0);
        bus.gntack = 1'b1; bus.done = 1'b1; step();
        bus.gntack = 1'b0; bus.done = 1'b0; step();
        chk("t5_late_gntv", int'(bus.gntv), 0);
        chk("t5_late_busy", int'(bus.busy), 0);

        // DONE for INT coinciding with a new INT edge: set wins
        bus.req = 5'b00100; step(); bus.req = '0;
        wait_gntv(10);
        chk("t6_idx2", int'(bus.gntidx), 2);
        bus.gntack = 1'b1; step(); bus.gntack = 1'b0;
        bus.req = 5'b00100; bus.done = 1'b1; step();
        bus.req = '0; bus.done = 1'b0;
        chk("t6_pend", int'(bus.pend), 5'b00100);
        chk("t6_idle", int'(bus.busy), 0);
        step();
        chk("t6_regrant", int'(bus.gntv), 1);
        do_grant(2);

        // Randomized traffic, checked by the per-cycle model comparison
        for (int c = 0; c < 4000; c++) begin
            bit [4:0] r;
            r = 5'($urandom & $urandom & $urandom);
            if ((c / 500) % 2 == 1) r[4] = 1'b1;
            bus.req    = r;
            bus.gntack = ($urandom % 2) == 0;
            bus.done   = ($urandom % 3) == 0;
            rstn       = ($urandom % 700) != 0;
            step();
        end
        rstn = 1'b1; bus.req = '0; bus.gntack = 1'b0; bus.done = 1'b0;
        step(); step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
